unsigned_div_16by8_seq: RTL and testbench
=========================================

UNSIGNED_DIV_16BY8_SEQ -- requirements
Module: unsigned_div_16by8_seq

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 16-bit dividend, 8-bit divisor, quotient and remainder.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  dividend/divisor pair offered.
REQ-005 in_ready  output  1  block able to accept a pair.
REQ-006 z  input  16  unsigned dividend, e.g. a product from the 8x8 multipliers.
REQ-007 y  input  8  unsigned divisor.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 x  output  8  unsigned quotient.
REQ-011 r  output  8  unsigned remainder.
REQ-012 dbz  output  1  divide-by-zero flag, qualified by out_valid.
REQ-013 ovf  output  1  quotient-overflow flag, qualified by out_valid.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept occurs on in_valid && in_ready.
REQ-016 On accept, z and y SHALL be registered, and inputs SHALL be ignored until the FSM next reaches IDLE.
REQ-017 If y == 0, the FSM SHALL go to DONE with dbz=1, ovf=0, x=8'hFF, r=z[7:0].
REQ-018 Else if z[15:8] >= y, the FSM SHALL go to DONE with ovf=1, dbz=0, x=8'hFF, r=8'hFF; dbz takes precedence over ovf.
REQ-019 Otherwise the FSM SHALL enter RUN with partial remainder = {1'b0, z[15:8]} (9 bits) and step counter = 0.
REQ-020 Each RUN cycle SHALL do one restoring step: shift in the next z[7:0] bit, MSB first; if the 9-bit value >= y, subtract y and record quotient bit 1, else record 0.
REQ-021 After exactly 8 RUN cycles the FSM SHALL enter DONE with x = floor(z/y) and r = z mod y; the remainder always fits 8 bits.
REQ-022 Latency SHALL be: accept in cycle 0; out_valid high from cycle 9 for the normal path and from cycle 1 for the dbz/ovf paths.
REQ-023 In DONE, out_valid=1, and x, r, dbz and ovf SHALL hold stable until out_valid && out_ready.
REQ-024 On that handshake the FSM SHALL return to IDLE next cycle, so in_ready=1 one cycle after the output handshake; input and output SHALL never overlap.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 Throughput SHALL be at most one division per 10 cycles, given out_ready=1 in DONE.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and out_valid, x, r, dbz, ovf and the step counter SHALL be 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 rst during RUN or DONE SHALL abort the operation and discard the result; no out_valid SHALL follow.

Structure
REQ-030 Package unsigned_div_pkg SHALL hold the state enum (IDLE, RUN, DONE), DIVIDEND_W=16, DIVISOR_W=8, STEPS=8, and the saturation constant SAT=8'hFF.
REQ-031 One combinational sub-module, unsigned_div_step, SHALL implement a single restoring step: (9-bit rem, next bit, divisor) -> (next rem, quotient bit).
REQ-032 Datapath SHALL be one shared step instance, a 9-bit remainder register, an 8-bit quotient shift register and a 3-bit step counter; there SHALL be no unrolled array.

Verification
REQ-033 z=16'h03E8, y=8'h07 -> x=8'h8E, r=8'h06, dbz=0, ovf=0, out_valid in cycle 9 after accept.
REQ-034 z=16'h1234, y=8'h00 -> dbz=1, ovf=0, x=8'hFF, r=8'h34, out_valid in cycle 1 after accept.
REQ-035 z=16'h0100, y=8'h01 -> ovf=1, dbz=0, x=8'hFF, r=8'hFF; and z=16'hFE01, y=8'hFF -> x=8'hFF, r=8'h00 via the normal path.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> outputs unchanged and in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-037 Assert rst in RUN cycle 4 -> out_valid stays 0, all outputs 0, in_ready=1 the cycle after rst falls; the next division completes correctly.
REQ-038 Exhaustive sweep: for all a, b in 0..255 with b != 0, apply z=a*b, y=b -> x=a, r=0, except ovf when a*b >= 256*b; also check random z against the z/y and z%y reference model.

Source files
------------

// File: rtl/unsigned_div_pkg.sv
// Shared types and constants for the sequential 16/8 unsigned divider.
package unsigned_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int STEPS      = 8;
  localparam logic [DIVISOR_W-1:0] SAT = 8'hFF;

endpackage

// File: rtl/unsigned_div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, subtract the divisor if it fits and emit the quotient bit.
module unsigned_div_step
  import unsigned_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? diff : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/unsigned_div_16by8_seq.sv
// Sequential 16/8 unsigned divider: one restoring step per cycle, with
// early exit for divide-by-zero and quotient overflow.
module unsigned_div_16by8_seq
  import unsigned_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] z,
  input  logic [DIVISOR_W-1:0]  y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVISOR_W-1:0]  x,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  dbz,
  output logic                  ovf
);

  state_t               state_reg, state_next;
  logic [DIVISOR_W:0]   rem_reg;
  logic [DIVISOR_W-1:0] quo_reg;
  logic [DIVISOR_W-1:0] z_lo_reg;
  logic [DIVISOR_W-1:0] y_reg;
  logic [2:0]           cnt_reg;
  logic                 dbz_reg, ovf_reg;

  logic                 accept, is_zero, is_ovf, last_step;
  logic [DIVISOR_W:0]   step_rem;
  logic                 step_q;

  assign accept    = in_valid && in_ready;
  assign is_zero   = (y == '0);
  assign is_ovf    = (z[DIVIDEND_W-1:DIVISOR_W] >= y);
  assign last_step = (cnt_reg == 3'(STEPS - 1));

  unsigned_div_step u_step (
    .rem_in  (rem_reg),
    .bit_in  (z_lo_reg[DIVISOR_W-1]),
    .divisor (y_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (is_zero || is_ovf) ? DONE : RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      z_lo_reg <= '0;
      y_reg    <= '0;
      cnt_reg  <= '0;
      dbz_reg  <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          y_reg    <= y;
          z_lo_reg <= z[DIVISOR_W-1:0];
          cnt_reg  <= '0;
          dbz_reg  <= is_zero;
          ovf_reg  <= !is_zero && is_ovf;
          // dbz wins over ovf; both saturate the quotient
          if (is_zero) begin
            quo_reg <= SAT;
            rem_reg <= {1'b0, z[DIVISOR_W-1:0]};
          end else if (is_ovf) begin
            quo_reg <= SAT;
            rem_reg <= {1'b0, SAT};
          end else begin
            quo_reg <= '0;
            rem_reg <= {1'b0, z[DIVIDEND_W-1:DIVISOR_W]};
          end
        end
        RUN: begin
          rem_reg  <= step_rem;
          quo_reg  <= {quo_reg[DIVISOR_W-2:0], step_q};
          z_lo_reg <= {z_lo_reg[DIVISOR_W-2:0], 1'b0};
          cnt_reg  <= cnt_reg + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign x   = quo_reg;
  assign r   = rem_reg[DIVISOR_W-1:0];
  assign dbz = dbz_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Self-checking bench: directed vector table, hold/reset corner cases,
// strided product sweep and random operands against an arithmetic model.
module tb_unsigned_div_16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  x;
  logic [7:0]  r;
  logic        dbz;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unsigned_div_16by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .r         (r),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] z;
    logic [7:0]  y;
    logic [7:0]  x;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division plus the saturation rules
  function automatic void model(input logic [15:0] zz, input logic [7:0] yy,
                                output logic [7:0] ex, output logic [7:0] er,
                                output logic edbz, output logic eovf, output int elat);
    int zi, yi;
    zi = int'(zz);
    yi = int'(yy);
    edbz = 1'b0; eovf = 1'b0;
    if (yi == 0) begin
      edbz = 1'b1; ex = 8'hFF; er = zz[7:0]; elat = 1;
    end else if (zi / 256 >= yi) begin
      eovf = 1'b1; ex = 8'hFF; er = 8'hFF; elat = 1;
    end else begin
      ex = 8'(zi / yi); er = 8'(zi % yi); elat = 9;
    end
  endfunction

  task automatic start_div(input logic [15:0] zz, input logic [7:0] yy);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1; z = zz; y = yy;
    @(posedge clk); #1;
    in_valid = 1'b0; z = $urandom; y = $urandom;
  endtask

  // Returns cycles from accept until out_valid (0 on timeout)
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      checks++; errors++; lat = 0;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic finish_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] zz, input logic [7:0] yy,
                               input logic chk_lat);
    logic [7:0] ex, er;
    logic edbz, eovf;
    int elat, lat;
    model(zz, yy, ex, er, edbz, eovf, elat);
    start_div(zz, yy);
    wait_result(lat);
    check({tag, ".x"}, {8'h0, x}, {8'h0, ex});
    check({tag, ".r"}, {8'h0, r}, {8'h0, er});
    if (edbz || eovf) begin
      check({tag, ".dbz"}, {15'h0, dbz}, {15'h0, edbz});
      check({tag, ".ovf"}, {15'h0, ovf}, {15'h0, eovf});
    end
    if (chk_lat) check({tag, ".lat"}, 16'(lat), 16'(elat));
    finish_result();
    if (chk_lat) check({tag, ".in_ready_after"}, {15'h0, in_ready}, 16'h1);
  endtask

  initial begin
    logic [7:0] hx, hr;
    logic       hd, ho;
    int         lat, b;

    vecs[0] = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9};
    vecs[1] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
    vecs[2] = '{16'h0100, 8'h01, 8'hFF, 8'hFF, 1'b0, 1'b1, 1};
    vecs[3] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
    vecs[4] = '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9};
    vecs[5] = '{16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
    vecs[6] = '{16'h04FF, 8'h05, 8'hFF, 8'h04, 1'b0, 1'b0, 9};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", {15'h0, out_valid}, 16'h0);
    check("rst.x", {8'h0, x}, 16'h0);
    check("rst.r", {8'h0, r}, 16'h0);
    check("rst.dbz", {15'h0, dbz}, 16'h0);
    check("rst.ovf", {15'h0, ovf}, 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready", {15'h0, in_ready}, 16'h1);

    // Directed table
    foreach (vecs[i]) begin
      start_div(vecs[i].z, vecs[i].y);
      wait_result(lat);
      check("vec.lat", 16'(lat), 16'(vecs[i].lat));
      check("vec.x", {8'h0, x}, {8'h0, vecs[i].x});
      check("vec.r", {8'h0, r}, {8'h0, vecs[i].r});
      check("vec.dbz", {15'h0, dbz}, {15'h0, vecs[i].dbz});
      check("vec.ovf", {15'h0, ovf}, {15'h0, vecs[i].ovf});
      finish_result();
      check("vec.in_ready_after", {15'h0, in_ready}, 16'h1);
      $display("vec %0d: z=%04h y=%02h -> x=%02h r=%02h dbz=%0b ovf=%0b lat=%0d",
               i, vecs[i].z, vecs[i].y, vecs[i].x, vecs[i].r, vecs[i].dbz, vecs[i].ovf, lat);
    end

    // Back-pressure: result must hold while out_ready stays low
    start_div(16'h03E8, 8'h07);
    wait_result(lat);
    hx = x; hr = r; hd = dbz; ho = ovf;
    check("hold.x0", {8'h0, hx}, 16'h008E);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold.out_valid", {15'h0, out_valid}, 16'h1);
      check("hold.in_ready", {15'h0, in_ready}, 16'h0);
      check("hold.x", {8'h0, x}, {8'h0, hx});
      check("hold.r", {8'h0, r}, {8'h0, hr});
      check("hold.flags", {14'h0, dbz, ovf}, {14'h0, hd, ho});
    end
    finish_result();
    check("hold.in_ready_after", {15'h0, in_ready}, 16'h1);
    $display("hold: x=%02h r=%02h held 5 cycles", hx, hr);

    // Reset in the middle of RUN discards the operation
    start_div(16'h03E8, 8'h07);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.in_ready", {15'h0, in_ready}, 16'h1);
    check("abort.x", {8'h0, x}, 16'h0);
    check("abort.r", {8'h0, r}, 16'h0);
    check("abort.flags", {14'h0, dbz, ovf}, 16'h0);
    for (int k = 0; k < 12; k++) begin
      check("abort.out_valid", {15'h0, out_valid}, 16'h0);
      @(posedge clk); #1;
    end
    run_and_check("abort.next", 16'h03E8, 8'h07, 1'b1);
    $display("abort: reset in RUN cycle 4, follow-up division checked");

    // Product sweep: z = a*b must divide back to a with zero remainder
    b = 1;
    while (b <= 256) begin
      logic [7:0] bb;
      bb = (b > 255) ? 8'hFF : 8'(b);
      for (int a = 0; a < 256; a++) begin
        logic [15:0] zp;
        zp = 16'(a * int'(bb));
        start_div(zp, bb);
        wait_result(lat);
        check("sweep.x", {8'h0, x}, 16'(a));
        check("sweep.r", {8'h0, r}, 16'h0);
        check("sweep.flags", {14'h0, dbz, ovf}, 16'h0);
        finish_result();
      end
      $display("sweep: b=%0d all a checked", bb);
      b += 17;
    end

    // Random operands against the model, including y=0 and overflow
    for (int k = 0; k < 600; k++) begin
      logic [15:0] rz;
      logic [7:0]  ry;
      rz = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       ry = 8'h00;
        1:       ry = 8'($urandom_range(1, 15));
        default: ry = 8'($urandom);
      endcase
      run_and_check("rand", rz, ry, 1'b1);
      if (k % 100 == 0) $display("rand %0d: z=%04h y=%02h -> x=%02h r=%02h", k, rz, ry, x, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
